// File: rtl/serv_fetch.sv
// Instruction fetch front end for a bit-serial core: single Wishbone master
// with a one-entry prefetch buffer holding the next sequential word.
module serv_fetch #(
  parameter int unsigned PREFETCH = 1
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [31:0] i_pc,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic [29:0] o_rdt,
  output logic        o_valid,
  output logic        o_busy
);

  // StFetch: demand in flight; StPref: speculative; StPmiss: speculative but demand differs
  typedef enum logic [1:0] {StIdle, StFetch, StPref, StPmiss} state_e;

  state_e      state_q, state_d;
  logic [29:0] adr_q, adr_d;
  logic        cyc_q, cyc_d;
  logic [29:0] rdt_q, rdt_d;
  logic        valid_q, valid_d;
  logic        buf_valid_q, buf_valid_d;
  logic [29:0] buf_adr_q, buf_adr_d;
  logic [29:0] buf_dat_q, buf_dat_d;
  logic [29:0] miss_pc_q, miss_pc_d;

  logic [29:0] pc_w;
  logic        ack_w;
  logic        hit_w;
  logic        unused_w;

  assign pc_w     = i_pc[31:2];
  assign ack_w    = cyc_q & i_ibus_ack;
  assign hit_w    = buf_valid_q && (buf_adr_q == pc_w);
  assign unused_w = ^{i_pc[1:0], i_ibus_rdt[1:0]};

  // Next-state and datapath decisions for the fetch FSM and prefetch buffer
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    cyc_d       = cyc_q;
    rdt_d       = rdt_q;
    valid_d     = 1'b0;
    buf_valid_d = buf_valid_q;
    buf_adr_d   = buf_adr_q;
    buf_dat_d   = buf_dat_q;
    miss_pc_d   = miss_pc_q;

    unique case (state_q)
      StIdle: begin
        if (i_req) begin
          buf_valid_d = 1'b0;
          if (hit_w) begin
            rdt_d   = buf_dat_q;
            valid_d = 1'b1;
            if (PREFETCH != 0) begin
              adr_d   = pc_w + 30'd1;
              state_d = StPref;
            end
          end else begin
            adr_d   = pc_w;
            cyc_d   = 1'b1;
            state_d = StFetch;
          end
        end
      end

      StFetch: begin
        if (!cyc_q) begin
          // Entered after a forced idle cycle; issue the demand now
          cyc_d = 1'b1;
        end else if (ack_w) begin
          rdt_d   = i_ibus_rdt[31:2];
          valid_d = 1'b1;
          cyc_d   = 1'b0;
          if (PREFETCH != 0) begin
            adr_d   = adr_q + 30'd1;
            state_d = StPref;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StPref: begin
        if (!cyc_q) begin
          // Prefetch not yet on the bus: a demand simply takes its place
          cyc_d = 1'b1;
          if (i_req) begin
            adr_d   = pc_w;
            state_d = StFetch;
          end
        end else if (i_req && (pc_w == adr_q)) begin
          if (ack_w) begin
            rdt_d   = i_ibus_rdt[31:2];
            valid_d = 1'b1;
            cyc_d   = 1'b0;
            adr_d   = adr_q + 30'd1;
          end else begin
            state_d = StFetch;
          end
        end else if (i_req) begin
          if (ack_w) begin
            cyc_d   = 1'b0;
            adr_d   = pc_w;
            state_d = StFetch;
          end else begin
            miss_pc_d = pc_w;
            state_d   = StPmiss;
          end
        end else if (ack_w) begin
          buf_dat_d   = i_ibus_rdt[31:2];
          buf_adr_d   = adr_q;
          buf_valid_d = 1'b1;
          cyc_d       = 1'b0;
          state_d     = StIdle;
        end
      end

      StPmiss: begin
        // Let the stale prefetch finish, drop its data, then fetch the demand
        if (ack_w) begin
          cyc_d   = 1'b0;
          adr_d   = miss_pc_q;
          state_d = StFetch;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; reset abandons any bus cycle
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      adr_q       <= '0;
      cyc_q       <= 1'b0;
      rdt_q       <= '0;
      valid_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_adr_q   <= '0;
      buf_dat_q   <= '0;
      miss_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      cyc_q       <= cyc_d;
      rdt_q       <= rdt_d;
      valid_q     <= valid_d;
      buf_valid_q <= buf_valid_d;
      buf_adr_q   <= buf_adr_d;
      buf_dat_q   <= buf_dat_d;
      miss_pc_q   <= miss_pc_d;
    end
  end

  // Registered outputs
  always_comb begin
    o_ibus_adr = {adr_q, 2'b00};
    o_ibus_cyc = cyc_q;
    o_rdt      = rdt_q;
    o_valid    = valid_q;
    o_busy     = (state_q == StFetch) || (state_q == StPmiss);
  end

endmodule

// File: tb/tb_serv_fetch.sv
// Bench for serv_fetch: one PREFETCH=1 instance driven by a table plus corner
// sequences, one PREFETCH=0 instance for back-to-back demand fetches.
module tb_serv_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // PREFETCH=1 instance
  logic        req;
  logic [31:0] pc;
  logic [31:0] adr;
  logic        cyc;
  logic [31:0] bus_rdt;
  logic        bus_ack;
  logic [29:0] rdt;
  logic        valid;
  logic        busy;
  logic        resp_ack = 1'b0;
  logic [31:0] resp_rdt = '0;
  logic        stray;
  // PREFETCH=0 instance
  logic        req0;
  logic [31:0] pc0;
  logic [31:0] adr0;
  logic        cyc0;
  logic [31:0] rdt_in0 = '0;
  logic        ack0 = 1'b0;
  logic [29:0] rdt0;
  logic        valid0;
  logic        busy0;

  assign bus_ack = resp_ack | stray;
  assign bus_rdt = stray ? 32'hDEAD_BEEF : resp_rdt;

  serv_fetch #(.PREFETCH(1)) dut (
    .clk        (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_pc       (pc),
    .o_ibus_adr (adr),
    .o_ibus_cyc (cyc),
    .i_ibus_rdt (bus_rdt),
    .i_ibus_ack (bus_ack),
    .o_rdt      (rdt),
    .o_valid    (valid),
    .o_busy     (busy)
  );

  serv_fetch #(.PREFETCH(0)) dut0 (
    .clk        (clk),
    .i_rst      (rst),
    .i_req      (req0),
    .i_pc       (pc0),
    .o_ibus_adr (adr0),
    .o_ibus_cyc (cyc0),
    .i_ibus_rdt (rdt_in0),
    .i_ibus_ack (ack0),
    .o_rdt      (rdt0),
    .o_valid    (valid0),
    .o_busy     (busy0)
  );

  int total = 0;
  int bad   = 0;
  int dly   = 1;
  logic [29:0] sb[$];
  logic [31:0] blog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem = 32'h0050_0093;
      32'h0000_0104: mem = 32'h0020_8133;
      default:       mem = {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
    endcase
  endfunction

  function automatic logic [29:0] exp_rdt(input logic [31:0] a);
    logic [31:0] w;
    w = mem(a);
    return w[31:2];
  endfunction

  // Monitor + bus responder for the PREFETCH=1 instance
  logic        p_cyc = 1'b0, p_ack = 1'b0, p_rst = 1'b1, p_valid = 1'b0;
  logic [29:0] last_rdt = '0;
  logic [29:0] sb_e;
  int          cnt = 0;
  always @(negedge clk) begin
    if (p_cyc && p_ack) check("cyc_gap", {31'd0, cyc}, 32'd0);
    else if (p_cyc && !p_rst) check("cyc_hold", {31'd0, cyc}, 32'd1);
    if (cyc && !p_cyc) blog.push_back(adr);
    if (valid) begin
      check("valid_pulse", {31'd0, p_valid}, 32'd0);
      check("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        sb_e = sb.pop_front();
        check("rdt", {2'b00, rdt}, {2'b00, sb_e});
      end
    end else if (!p_rst) begin
      check("rdt_hold", {2'b00, rdt}, {2'b00, last_rdt});
    end
    if (rst) begin
      resp_ack = 1'b0;
      cnt      = 0;
    end else if (cyc && !resp_ack) begin
      if (cnt >= dly) begin
        resp_ack = 1'b1;
        resp_rdt = mem(adr);
      end else begin
        cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      cnt      = 0;
    end
    p_cyc    = cyc;
    p_ack    = resp_ack | stray;
    p_rst    = rst;
    p_valid  = valid;
    last_rdt = rdt;
  end

  // Responder for the PREFETCH=0 instance: acks one cycle after issue
  logic p_cyc0 = 1'b0, p_ack0 = 1'b0;
  int   rises0 = 0;
  always @(negedge clk) begin
    if (cyc0 && !p_cyc0) rises0++;
    if (p_cyc0 && p_ack0) check("cyc_gap0", {31'd0, cyc0}, 32'd0);
    if (cyc0 && !ack0) begin
      ack0    = 1'b1;
      rdt_in0 = mem(adr0);
    end else begin
      ack0 = 1'b0;
    end
    p_cyc0 = cyc0;
    p_ack0 = ack0;
  end

  task automatic do_req(input logic [31:0] a);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("not_busy", {31'd0, busy}, 32'd0);
    req = 1'b1;
    pc  = a;
    sb.push_back(exp_rdt(a));
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  task automatic wait_pref(input logic [31:0] a);
    int n;
    n = 0;
    while (!(cyc && adr == a) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pref_issued", adr, a);
  endtask

  task automatic wait_valid0(input logic [31:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!valid0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("valid0_seen", {31'd0, valid0}, 32'd1);
    check("rdt0", {2'b00, rdt0}, {2'b00, exp_rdt(a)});
  endtask

  typedef struct {
    logic [31:0] pc;
    int          dly;
    bit          miss;
  } vec_t;

  vec_t vecs[7];
  int   n0;

  initial begin
    vecs[0] = '{32'h0000_0100, 2, 1'b1};
    vecs[1] = '{32'h0000_0104, 0, 1'b0};
    vecs[2] = '{32'h0000_0108, 1, 1'b0};
    vecs[3] = '{32'h0000_0300, 3, 1'b1};
    vecs[4] = '{32'h0000_0304, 0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFC, 1, 1'b1};
    vecs[6] = '{32'h0000_0000, 2, 1'b0};

    rst = 1'b1; req = 1'b0; pc = '0; stray = 1'b0; req0 = 1'b0; pc0 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_adr", adr, 32'd0);
    check("rst_cyc", {31'd0, cyc}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdt", {2'b00, rdt}, 32'd0);
    check("rst_cyc0", {31'd0, cyc0}, 32'd0);

    // PREFETCH=0: two back-to-back demand fetches
    @(posedge clk); #1 req0 = 1'b1; pc0 = 32'h100;
    @(posedge clk); #1 req0 = 1'b0;
    wait_valid0(32'h100);
    @(posedge clk); #1 req0 = 1'b1; pc0 = 32'h104;
    @(posedge clk); #1 req0 = 1'b0;
    wait_valid0(32'h104);
    repeat (10) @(negedge clk);
    check("pf0_bus_count", rises0, 32'd2);

    // Sequential hits/misses through the prefetch buffer
    for (int i = 0; i < 7; i++) begin
      dly = vecs[i].dly;
      n0  = blog.size();
      do_req(vecs[i].pc);
      if (!vecs[i].miss) begin
        @(negedge clk);
        check("hit_latency", {31'd0, valid}, 32'd1);
      end
      drain();
      repeat (14) @(negedge clk);
      check("bus_count", blog.size() - n0, vecs[i].miss ? 32'd2 : 32'd1);
      if (vecs[i].miss && blog.size() > n0) check("demand_adr", blog[n0], vecs[i].pc);
      if (blog.size() > 0) check("pref_adr", blog[blog.size() - 1], vecs[i].pc + 32'd4);
    end

    // Ack with no cycle open must not disturb the buffered word
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    @(negedge clk);
    check("stray_cyc", {31'd0, cyc}, 32'd0);
    do_req(32'h4);
    @(negedge clk);
    check("stray_hit", {31'd0, valid}, 32'd1);
    drain();
    repeat (14) @(negedge clk);

    // Demand that misses an in-flight prefetch, then one that matches it
    dly = 4;
    n0  = blog.size();
    do_req(32'h100);
    drain();
    wait_pref(32'h104);
    do_req(32'h200);
    @(negedge clk);
    check("pmiss_busy", {31'd0, busy}, 32'd1);
    drain();
    wait_pref(32'h204);
    do_req(32'h204);
    drain();
    repeat (16) @(negedge clk);
    check("pmiss_count", blog.size() - n0, 32'd5);
    if (blog.size() >= n0 + 5) begin
      check("pmiss_stale", blog[n0 + 1], 32'h104);
      check("pmiss_demand", blog[n0 + 2], 32'h200);
      check("pref_join", blog[n0 + 3], 32'h204);
      check("pref_next", blog[n0 + 4], 32'h208);
    end

    // Reset during a demand fetch with an ack in the reset cycle
    dly = 1000;
    do_req(32'h400);
    @(posedge clk); #1 rst = 1'b1; stray = 1'b1;
    @(posedge clk); #1 rst = 1'b0; stray = 1'b0; sb.delete();
    @(negedge clk);
    check("mid_rst_cyc", {31'd0, cyc}, 32'd0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_adr", adr, 32'd0);
    dly = 1;
    n0  = blog.size();
    do_req(32'h400);
    drain();
    repeat (10) @(negedge clk);
    check("fresh_count", blog.size() - n0, 32'd2);
    if (blog.size() > n0) check("fresh_adr", blog[n0], 32'h400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
